nes_poll_controller: RTL and testbench
======================================

// Module: nes_poll_controller
// PURPOSE
//  Schedules reads of the SNES pad reader. Sits between the MU-facing register logic and the pad reader block.
//  Issues single-cycle frame pulses, either periodically (auto-poll) or on MU request, and waits for done with a timeout.
//  Captures the 16-bit result, inverted so that 1 = pressed, and raises a change interrupt.
// PARAMETERS
//  POLL_DIV    833333  clk cycles between auto-poll ticks (60 Hz at 50 MHz); must be >= 2
//  TIMEOUT_CYC 4096    max clk cycles from frame to done before abort (a reader frame is ~2300 cycles)
//  CNT_W       20      width of poll divider counter; must satisfy 2**CNT_W >= POLL_DIV
// PORTS
//  clk         in  1   system clock; all logic on rising edge
//  reset       in  1   asynchronous, active-high reset
//  enable      in  1   1 = auto-poll every POLL_DIV cycles
//  poll_now    in  1   1-cycle MU request for an immediate poll
//  clear_status in 1   1-cycle pulse; clears timeout_flag (and press_latch when PADPOLL_PRESS_LATCH_EN)
//  frame       out 1   1-cycle start pulse to the pad reader
//  done        in  1   pad reader done (level, held high ~64 clks)
//  nes_state   in  16  raw pad reader shift result (0 = pressed)
//  pad_state   out 16  last captured buttons, 1 = pressed
//  busy        out 1   high from the frame cycle until capture or abort
//  irq         out 1   1-cycle pulse when a capture differs from the previous pad_state
//  timeout_flag out 1  sticky; set on abort
//  press_latch out 16  (PADPOLL_PRESS_LATCH_EN only) sticky newly-pressed buttons
// BEHAVIOUR
//  Reset values: frame=0, busy=0, irq=0, timeout_flag=0, pad_state=0, press_latch=0. FSM=IDLE; divider, pending, timer and done_q all cleared.
//  Divider: counts 0..POLL_DIV-1 while enable=1 and wraps; tick=1 for one cycle at POLL_DIV-1.
//   enable=0 holds the divider at 0, so the first tick comes POLL_DIV cycles after enable rises.
//  Request: req = poll_now | tick | pending. Requests arriving in FRAME/WAIT/CAPTURE set pending (1 deep; extra requests coalesce).
//  FSM:
//   IDLE    : req -> FRAME; clear pending. A simultaneous tick and poll_now start a single poll.
//   FRAME   : frame=1 for exactly this cycle; timer<=0 -> WAIT.
//   WAIT    : done rising edge (done & ~done_q) -> CAPTURE.
//             timer==TIMEOUT_CYC-1 -> IDLE, timeout_flag<=1, pad_state unchanged.
//             Otherwise timer++.
//   CAPTURE : pad_state<=~nes_state; irq=1 this cycle iff ~nes_state != pad_state (old value) -> IDLE.
//  busy = (FSM != IDLE), registered. Latency from poll_now in IDLE to frame is 1 cycle; from done edge to pad_state update is 1 cycle.
//  done_q samples done every cycle, so a done level still high when the next poll begins does not retrigger.
//  A done rising edge seen while in IDLE is ignored.
//  clear_status and a timeout in the same cycle: set wins.
//  Reset mid-poll: immediate return to IDLE with all outputs at reset values. The reader is reset by the same reset net.
// CONFIGURATION
//  PADPOLL_PRESS_LATCH_EN defined:
//   in CAPTURE, press_latch <= press_latch | (~nes_state & ~pad_state_old).
//   clear_status zeroes it; a capture in the same cycle wins for its new bits.
//  Undefined: press_latch is tied to 16'd0 and no flops are generated.
// TESTING (POLL_DIV=100, TIMEOUT_CYC=300, behavioural reader: done rises 50 clks after frame, held 64 clks)
//  1. enable=1, nes_state=16'hFFFF -> frame at cycle 100, 200, ...; pad_state=0; no irq.
//  2. nes_state=16'hFF7E, poll_now -> frame next cycle; pad_state=16'h0081 one cycle after done edge; irq once.
//  3. Repeat poll with the same nes_state -> pad_state holds 16'h0081; irq stays 0.
//  4. Reader never asserts done -> busy for 300 cycles then falls; timeout_flag=1; clear_status -> 0.
//  5. poll_now twice during WAIT plus a tick -> exactly one extra frame after capture (pending coalesced).
//  6. Assert reset during WAIT -> frame/busy/irq=0 and pad_state=0 immediately.
//     With PADPOLL_PRESS_LATCH_EN: 16'h0001 then 16'h0003 -> press_latch=16'h0003.

Source files
------------

// File: rtl/nes_poll_controller.sv
// nes_poll_controller: schedules SNES pad reads (auto-poll or on request) with timeout, captures inverted buttons.
// Optional PADPOLL_PRESS_LATCH_EN adds a sticky newly-pressed latch.
module nes_poll_controller #(
  parameter int POLL_DIV    = 833333,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        poll_now,
  input  logic        clear_status,
  output logic        frame,
  input  logic        done,
  input  logic [15:0] nes_state,
  output logic [15:0] pad_state,
  output logic        busy,
  output logic        irq,
  output logic        timeout_flag,
  output logic [15:0] press_latch
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, FRAME, WAIT, CAPTURE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0] timer;
  logic pending, done_q, tick, req, done_rise, expired, abort;
  assign tick = enable && cnt == CNT_W'(POLL_DIV - 1);
  assign req = poll_now | tick | pending;
  assign done_rise = done & ~done_q;
  assign expired = timer == TW'(TIMEOUT_CYC - 1);
  assign abort = state == WAIT && !done_rise && expired;
  assign frame = state == FRAME;
  assign busy = state != IDLE;
  assign irq = state == CAPTURE && ~nes_state != pad_state;
  always_comb begin
    state_nx = state == IDLE  ? (req ? FRAME : IDLE) :
               state == FRAME ? WAIT :
               state == WAIT  ? (done_rise ? CAPTURE : expired ? IDLE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      timer <= '0;
      pending <= 1'b0;
      done_q <= 1'b0;
      pad_state <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_nx;
      done_q <= done;
      cnt <= (!enable || tick) ? '0 : cnt + 1'b1;
      // requests seen while a poll is in flight collapse into a single follow-up poll
      pending <= state == IDLE ? 1'b0 : pending | poll_now | tick;
      timer <= state == WAIT ? timer + 1'b1 : '0;
      if (state == CAPTURE) pad_state <= ~nes_state;
      timeout_flag <= abort | (timeout_flag & ~clear_status);
    end
`ifdef PADPOLL_PRESS_LATCH_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) press_latch <= '0;
    else press_latch <= (clear_status ? '0 : press_latch) |
                        (state == CAPTURE ? ~nes_state & ~pad_state : '0);
`else
  assign press_latch = '0;
`endif
endmodule

// File: tb/tb_nes_poll_controller.sv
// tb_nes_poll_controller: directed vector table plus sequences for auto-poll, timeout, pending and reset.
module tb_nes_poll_controller;
  logic clk = 0, reset = 1, enable = 0, poll_now = 0, clear_status = 0, done, frame, busy, irq, timeout_flag;
  logic [15:0] nes_state = 16'hFFFF, pad_state, press_latch;
  logic dead = 0;
  int rd_cnt;
  int tests = 0, fails = 0;
`ifdef PADPOLL_PRESS_LATCH_EN
  localparam bit LATCH = 1;
`else
  localparam bit LATCH = 0;
`endif
  nes_poll_controller #(.POLL_DIV(100), .TIMEOUT_CYC(300), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .enable(enable), .poll_now(poll_now), .clear_status(clear_status),
    .frame(frame), .done(done), .nes_state(nes_state), .pad_state(pad_state), .busy(busy),
    .irq(irq), .timeout_flag(timeout_flag), .press_latch(press_latch));
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) begin
      rd_cnt <= 0;
      done <= 0;
    end else begin
      if (frame && !dead) rd_cnt <= 1;
      else if (rd_cnt != 0 && rd_cnt < 120) rd_cnt <= rd_cnt + 1;
      else rd_cnt <= 0;
      done <= rd_cnt >= 50 && rd_cnt < 114;
    end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_poll(output int irqs);
    irqs = 0;
    poll_now = 1;
    @(negedge clk);
    poll_now = 0;
    for (int k = 0; k < 400 && busy; k++) begin
      irqs += int'(irq);
      @(negedge clk);
    end
    chk("poll_finished", busy, 0);
  endtask
  typedef struct {
    logic [15:0] nes;
    logic clr;
    logic [15:0] pad;
    int irqs;
    logic [15:0] latch;
  } vec_t;
  vec_t v[7];
  initial begin
    int f1, f2, nirq, nfr, n;
    v[0] = '{16'hFFFF, 0, 16'h0000, 0, 16'h0000};
    v[1] = '{16'hFF7E, 0, 16'h0081, 1, 16'h0081};
    v[2] = '{16'hFF7E, 0, 16'h0081, 0, 16'h0081};
    v[3] = '{16'h0000, 0, 16'hFFFF, 1, 16'hFFFF};
    v[4] = '{16'hFFFF, 1, 16'h0000, 1, 16'h0000};
    v[5] = '{16'hFFFE, 0, 16'h0001, 1, 16'h0001};
    v[6] = '{16'hFFFC, 0, 16'h0003, 1, 16'h0003};
    @(negedge clk);
    chk("rst_frame", frame, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pad", pad_state, 0);
    chk("rst_timeout", timeout_flag, 0);
    @(negedge clk);
    reset = 0;
    // auto-poll: frames 100 and 200 cycles after enable rises
    f1 = -1; f2 = -1; nirq = 0;
    enable = 1;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      nirq += int'(irq);
      if (frame) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
    end
    enable = 0;
    chk("tick_frame1", f1, 100);
    chk("tick_frame2", f2, 200);
    chk("tick_irq", nirq, 0);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    chk("tick_idle", busy, 0);
    chk("tick_pad", pad_state, 0);
    for (int i = 0; i < 7; i++) begin
      if (v[i].clr) begin
        clear_status = 1;
        @(negedge clk);
        clear_status = 0;
      end
      nes_state = v[i].nes;
      do_poll(nirq);
      chk($sformatf("vec%0d_pad", i), pad_state, v[i].pad);
      chk($sformatf("vec%0d_irq", i), nirq, v[i].irqs);
      chk($sformatf("vec%0d_latch", i), press_latch, LATCH ? v[i].latch : 16'h0);
    end
    // timeout: FRAME cycle plus 300 WAIT cycles
    dead = 1;
    poll_now = 1;
    @(negedge clk);
    poll_now = 0;
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    dead = 0;
    chk("to_busy_len", n, 301);
    chk("to_flag", timeout_flag, 1);
    chk("to_pad_hold", pad_state, 16'h0003);
    clear_status = 1;
    @(negedge clk);
    clear_status = 0;
    chk("to_clear", timeout_flag, 0);
    // requests during WAIT (two poll_now plus a tick) yield one extra frame
    nfr = 0;
    enable = 1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      nfr += int'(frame);
      poll_now = (i == 60 || i == 70 || i == 80);
      if (i == 110) enable = 0;
    end
    chk("pend_frames", nfr, 2);
    chk("pend_idle", busy, 0);
    // async reset in the middle of WAIT
    nes_state = 16'hFF7E;
    poll_now = 1;
    @(negedge clk);
    poll_now = 0;
    repeat (20) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1;
    #1;
    chk("mrst_frame", frame, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_irq", irq, 0);
    chk("mrst_pad", pad_state, 0);
    chk("mrst_latch", press_latch, 0);
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
